unidad_busqueda: RTL and testbench
==================================

// Module: unidad_busqueda
// PURPOSE
//  Instruction-fetch initiator that drives the instruction memory's ADDR and samples its INST.
//  The memory read is combinational, so ADDR and INST resolve in the same cycle.
//  Holds the PC and buffers fetched {PC, INST} pairs in a small FIFO.
//  Hands the pairs to decode over a valid/ready handshake and flushes on branch/jump redirect.
// PARAMETERS
//  PC_INICIO    32'h0000_0000  reset vector, word aligned
//  PROFUNDIDAD  2              FIFO entries; power of two, >=2
// PORTS
//  CLK        in   1   single clock; all state updates on rising edge
//  RST_N      in   1   reset, asynchronous assert, active-low
//  ADDR       out  32  byte address to instruction memory (= PC register)
//  INST       in   32  instruction word returned combinationally for ADDR
//  SALTO      in   1   redirect request (taken branch/jump), 1-cycle pulse
//  DIR_SALTO  in   32  redirect target; bits [1:0] forced to 0
//  INST_VALID out  1   FIFO head holds a valid instruction
//  INST_READY in   1   decode accepts head this cycle
//  INST_OUT   out  32  head instruction
//  PC_OUT     out  32  byte address of head instruction
// BEHAVIOUR
//  Reset (RST_N=0, takes effect immediately):
//   - PC=PC_INICIO, so ADDR=PC_INICIO.
//   - FIFO empty; INST_VALID=0, INST_OUT=0, PC_OUT=0.
//  pop  = INST_VALID & INST_READY.
//  push = !SALTO & (!full | pop).
//   - push writes {PC, INST} at the tail and advances PC <= PC+4.
//   - PC wraps 32'hFFFF_FFFC -> 32'h0; no trap.
//  Full and pop in the same cycle: push and pop both occur, count unchanged.
//  Empty: no pop; push allowed. INST_VALID is driven from registered count (count!=0), never from INST.
//  SALTO=1 (highest priority):
//   - Clear all FIFO entries and set PC <= {DIR_SALTO[31:2], 2'b00}.
//   - No push in that cycle.
//   - A pop in the same cycle still counts as consumed by decode.
//   - Timing: cycle t SALTO; t+1 INST_VALID=0 and ADDR=target; t+2 INST_VALID=1 with PC_OUT=target.
//  First fetch after reset release: entry pushed at the first edge, so INST_VALID=1 one cycle after release.
//  Handshake rules:
//   - While INST_VALID=1 and INST_READY=0, INST_OUT and PC_OUT stay stable.
//   - INST_VALID falls only after a pop or a flush.
//  Sustained throughput: 1 instr/cycle when INST_READY is held at 1.
//  SALTO together with RST_N=0: reset wins.
//  Counters:
//   - Read/write pointers are clog2(PROFUNDIDAD) bits and wrap naturally.
//   - count is clog2(PROFUNDIDAD+1) bits.
// STRUCTURE
//  Shared package: ANCHO_INST=32, ANCHO_DIR=32, INCREMENTO_PC=4, PC_INICIO default.
//  Sub-module fifo_busqueda:
//   - Synchronous FIFO, width 64 ({pc, inst}), depth PROFUNDIDAD.
//   - Ports: push, pop, flush, full, empty, head data.
//   - Async active-low reset.
//  Top level holds the PC register, push/pop/flush logic and the ADDR drive.
// TESTING
//  1. Reset release, READY=1, memory word i = 32'hA000_0000+i:
//     ADDR steps 0,4,8...; INST_OUT A0000000, A0000001... one per cycle, PC_OUT matches.
//  2. READY=0 for 5 cycles after reset:
//     - FIFO fills to PROFUNDIDAD, ADDR freezes at 4*PROFUNDIDAD.
//     - Head holds PC_OUT=0.
//     - READY=1 then drains in order with no gap or duplicate.
//  3. SALTO=1, DIR_SALTO=32'h0000_0103 while FIFO full:
//     next cycle INST_VALID=0 and ADDR=32'h100; cycle after, PC_OUT=32'h100.
//  4. SALTO and pop in the same cycle:
//     - Popped entry is counted once.
//     - No stale pre-branch entry ever appears after the flush.
//  5. PC_INICIO=32'hFFFF_FFF8, READY=1: PC_OUT sequence FFFFFFF8, FFFFFFFC, 00000000.
//  6. RST_N low mid-stream with FIFO holding 2 entries:
//     - INST_VALID=0 and ADDR=PC_INICIO asynchronously, before the next edge.

Source files
------------

// File: rtl/unidad_busqueda_pkg.sv
// Shared widths, reset vector and fetch-entry layout for the fetch unit.
// Pure declarations; no timing.
// Entries travel as a packed {pc, inst} pair through the fetch FIFO.
package unidad_busqueda_pkg;

  localparam int ANCHO_INST = 32;
  localparam int ANCHO_DIR  = 32;
  localparam logic [ANCHO_DIR-1:0] INCREMENTO_PC = 32'd4;
  localparam logic [ANCHO_DIR-1:0] PC_INICIO_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [ANCHO_DIR-1:0]  pc;
    logic [ANCHO_INST-1:0] inst;
  } entrada_t;

  // Word-align a redirect target by clearing the byte-offset bits.
  function automatic logic [ANCHO_DIR-1:0] alinear(input logic [ANCHO_DIR-1:0] d);
    return d & ~(INCREMENTO_PC - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_busqueda.sv
// Synchronous FIFO holding fetched {pc, inst} pairs; head is visible combinationally from storage.
// Latency: a push is visible at the head one cycle later; flush empties it at the next edge.
// Backpressure: caller must not push when full unless popping in the same cycle; pop on empty is ignored.
module fifo_busqueda #(
  parameter int ANCHO       = 64,
  parameter int PROFUNDIDAD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [ANCHO-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [ANCHO-1:0] dout
);

  localparam int PW = $clog2(PROFUNDIDAD);
  localparam int CW = $clog2(PROFUNDIDAD + 1);

  logic [ANCHO-1:0] mem [PROFUNDIDAD];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop_ef;
  logic             push_ef;

  assign empty   = (count == '0);
  assign full    = (count == CW'(PROFUNDIDAD));
  assign pop_ef  = pop & ~empty;
  assign push_ef = push & (~full | pop_ef);
  // Empty head reads as zero so stale entries left behind by a flush never leak out.
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage write at the tail; contents need no reset because the head is gated by empty.
  always_ff @(posedge clk) begin
    if (push_ef && !flush) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush overrides any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ef) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ef)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ef, pop_ef})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction fetch: drives addr from the PC, captures {pc, inst} into a FIFO and hands it to decode.
// Latency: a fetched word appears at the head one cycle after its addr; redirect target appears two cycles after salto.
// Backpressure: inst_ready low stalls the PC once the FIFO is full; salto flushes and takes priority over fetch.
module unidad_busqueda
  import unidad_busqueda_pkg::*;
#(
  parameter logic [ANCHO_DIR-1:0] PC_INICIO   = PC_INICIO_DEF,
  parameter int                   PROFUNDIDAD = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ANCHO_DIR-1:0]  addr,
  input  logic [ANCHO_INST-1:0] inst,
  input  logic                  salto,
  input  logic [ANCHO_DIR-1:0]  dir_salto,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [ANCHO_INST-1:0] inst_out,
  output logic [ANCHO_DIR-1:0]  pc_out
);

  logic [ANCHO_DIR-1:0] pc;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push;
  entrada_t             entrada;
  entrada_t             cabeza;

  // Valid comes from the registered occupancy, never from the memory word itself.
  assign inst_valid = ~empty;
  assign pop        = inst_valid & inst_ready;
  assign push       = ~salto & (~full | pop);
  assign addr       = pc;
  assign entrada    = '{pc: pc, inst: inst};
  assign inst_out   = cabeza.inst;
  assign pc_out     = cabeza.pc;

  // PC: redirect wins, otherwise advance one word per accepted fetch (wraps at the top of memory).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_INICIO;
    end else if (salto) begin
      pc <= alinear(dir_salto);
    end else if (push) begin
      pc <= pc + INCREMENTO_PC;
    end
  end

  fifo_busqueda #(
    .ANCHO       ($bits(entrada_t)),
    .PROFUNDIDAD (PROFUNDIDAD)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (salto),
    .din   (entrada),
    .full  (full),
    .empty (empty),
    .dout  (cabeza)
  );

endmodule

// File: tb/tb_unidad_busqueda.sv
// Self-checking bench for unidad_busqueda: scoreboard of expected {pc, inst} entries plus fixed sequences.
// Inputs change at the falling edge; outputs are sampled 1 time unit after it.
// A second instance checks the PC wrap from a high reset vector.
module tb_unidad_busqueda;

  localparam int P = 2;

  logic        clk = 1'b0;
  logic        rst_n, rst_n2;
  logic [31:0] addr, addr2;
  logic [31:0] inst, inst2;
  logic        salto;
  logic [31:0] dir_salto;
  logic        inst_valid, inst_valid2;
  logic        inst_ready, inst_ready2;
  logic [31:0] inst_out, inst_out2;
  logic [31:0] pc_out, pc_out2;

  int pass  = 0;
  int total = 0;

  // Scoreboard: expected FIFO contents {pc, inst} and the model PC.
  logic [63:0] mq[$];
  logic [31:0] mpc;

  always #5 clk = ~clk;

  // Instruction memory: word i holds A000_0000 + i.
  assign inst  = 32'hA000_0000 + {2'b00, addr[31:2]};
  assign inst2 = 32'hA000_0000 + {2'b00, addr2[31:2]};

  unidad_busqueda #(.PC_INICIO(32'h0000_0000), .PROFUNDIDAD(P)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .inst(inst), .salto(salto),
    .dir_salto(dir_salto), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .pc_out(pc_out)
  );

  unidad_busqueda #(.PC_INICIO(32'hFFFF_FFF8), .PROFUNDIDAD(P)) dut2 (
    .clk(clk), .rst_n(rst_n2), .addr(addr2), .inst(inst2), .salto(1'b0),
    .dir_salto(32'h0), .inst_valid(inst_valid2), .inst_ready(inst_ready2),
    .inst_out(inst_out2), .pc_out(pc_out2)
  );

  function automatic logic [31:0] palabra(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  // Hold reset for two cycles, release on a falling edge, clear the model.
  task automatic reiniciar(input logic rdy);
    @(negedge clk);
    rst_n = 1'b0; salto = 1'b0; dir_salto = '0; inst_ready = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    mpc = 32'h0;
    #1;
  endtask

  // Advance one clock using the current inputs; the model predicts pop/push/flush from its own state.
  task automatic avanzar();
    bit vld, pp, ps;
    vld = (mq.size() != 0);
    pp  = vld && inst_ready;
    ps  = !salto && ((mq.size() < P) || pp);
    if (pp) void'(mq.pop_front());
    if (salto) begin
      mq.delete();
      mpc = dir_salto & 32'hFFFF_FFFC;
    end else if (ps) begin
      mq.push_back({mpc, palabra(mpc)});
      mpc = mpc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; salto = 1'b0; inst_ready = 1'b1; dir_salto = '0;
    #1;
    total++; if (addr !== 32'h0) $display("FAIL reset_addr got %h want %h", addr, 32'h0); else pass++;
    total++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", inst_valid); else pass++;
    total++; if (inst_out !== 32'h0) $display("FAIL reset_inst_out got %h want 0", inst_out); else pass++;
    total++; if (pc_out !== 32'h0) $display("FAIL reset_pc_out got %h want 0", pc_out); else pass++;
  endtask

  task automatic test_flujo();
    reiniciar(1'b1);
    total++; if (inst_valid !== 1'b0) $display("FAIL flujo_valid_release got %b want 0", inst_valid); else pass++;
    for (int k = 1; k <= 8; k++) begin
      avanzar();
      total++; if (inst_valid !== 1'b1) $display("FAIL flujo_valid k=%0d got %b want 1", k, inst_valid); else pass++;
      total++; if (pc_out !== 32'(4*(k-1))) $display("FAIL flujo_pc k=%0d got %h want %h", k, pc_out, 32'(4*(k-1))); else pass++;
      total++; if (inst_out !== 32'hA000_0000 + 32'(k-1)) $display("FAIL flujo_inst k=%0d got %h want %h", k, inst_out, 32'hA000_0000 + 32'(k-1)); else pass++;
      total++; if (addr !== 32'(4*k)) $display("FAIL flujo_addr k=%0d got %h want %h", k, addr, 32'(4*k)); else pass++;
    end
  endtask

  task automatic test_contrapresion();
    reiniciar(1'b0);
    for (int k = 1; k <= 5; k++) begin
      avanzar();
      total++; if (addr !== 32'(4*((k < P) ? k : P))) $display("FAIL stall_addr k=%0d got %h want %h", k, addr, 32'(4*((k < P) ? k : P))); else pass++;
      total++; if (pc_out !== 32'h0) $display("FAIL stall_head k=%0d got %h want 0", k, pc_out); else pass++;
      total++; if (mq.size() == 0 || inst_out !== mq[0][31:0]) $display("FAIL stall_sb k=%0d got %h", k, inst_out); else pass++;
    end
    inst_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      total++; if (pc_out !== 32'(4*j)) $display("FAIL drain_pc j=%0d got %h want %h", j, pc_out, 32'(4*j)); else pass++;
      total++; if (inst_valid !== 1'b1) $display("FAIL drain_valid j=%0d got %b want 1", j, inst_valid); else pass++;
      total++; if (addr !== 32'(4*P + 4*j)) $display("FAIL drain_addr j=%0d got %h want %h", j, addr, 32'(4*P + 4*j)); else pass++;
      avanzar();
    end
  endtask

  task automatic test_salto();
    reiniciar(1'b0);
    repeat (3) avanzar();
    salto = 1'b1; dir_salto = 32'h0000_0103;
    avanzar();
    salto = 1'b0;
    total++; if (inst_valid !== 1'b0) $display("FAIL salto_valid_t1 got %b want 0", inst_valid); else pass++;
    total++; if (addr !== 32'h100) $display("FAIL salto_addr_t1 got %h want 100", addr); else pass++;
    avanzar();
    total++; if (inst_valid !== 1'b1) $display("FAIL salto_valid_t2 got %b want 1", inst_valid); else pass++;
    total++; if (pc_out !== 32'h100) $display("FAIL salto_pc_t2 got %h want 100", pc_out); else pass++;
    total++; if (inst_out !== 32'hA000_0040) $display("FAIL salto_inst_t2 got %h want A0000040", inst_out); else pass++;
  endtask

  task automatic test_salto_pop();
    logic [31:0] obs[$];
    logic [31:0] esperado[5];
    esperado = '{32'h0, 32'h4, 32'h8, 32'h200, 32'h204};
    reiniciar(1'b1);
    for (int c = 0; c < 7; c++) begin
      salto = (c == 3);
      dir_salto = 32'h0000_0200;
      if (inst_valid && inst_ready) obs.push_back(pc_out);
      if (mq.size() != 0) begin
        total++; if (pc_out !== mq[0][63:32] || inst_out !== mq[0][31:0]) $display("FAIL salto_pop_sb c=%0d got %h/%h want %h", c, pc_out, inst_out, mq[0]); else pass++;
      end
      avanzar();
    end
    salto = 1'b0;
    total++; if (obs.size() != 5) $display("FAIL salto_pop_count got %0d want 5", obs.size()); else pass++;
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      total++; if (obs[i] !== esperado[i]) $display("FAIL salto_pop_seq i=%0d got %h want %h", i, obs[i], esperado[i]); else pass++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] esperado[3];
    esperado = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    @(negedge clk);
    inst_ready2 = 1'b1;
    rst_n2 = 1'b1;
    #1;
    total++; if (addr2 !== 32'hFFFF_FFF8) $display("FAIL wrap_addr_release got %h want FFFFFFF8", addr2); else pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++; if (pc_out2 !== esperado[i]) $display("FAIL wrap_pc i=%0d got %h want %h", i, pc_out2, esperado[i]); else pass++;
      total++; if (inst_out2 !== palabra(esperado[i])) $display("FAIL wrap_inst i=%0d got %h want %h", i, inst_out2, palabra(esperado[i])); else pass++;
    end
  endtask

  task automatic test_reset_asincrono();
    reiniciar(1'b0);
    repeat (2) avanzar();
    total++; if (inst_valid !== 1'b1 || mq.size() != 2) $display("FAIL areset_pre_valid got %b want 1", inst_valid); else pass++;
    #2;
    rst_n = 1'b0;
    salto = 1'b1; dir_salto = 32'h0000_0300;
    #1;
    total++; if (inst_valid !== 1'b0) $display("FAIL areset_valid got %b want 0", inst_valid); else pass++;
    total++; if (addr !== 32'h0) $display("FAIL areset_addr got %h want 0", addr); else pass++;
    total++; if (pc_out !== 32'h0) $display("FAIL areset_pc_out got %h want 0", pc_out); else pass++;
    @(posedge clk); #1;
    total++; if (addr !== 32'h0) $display("FAIL areset_salto_addr got %h want 0", addr); else pass++;
    salto = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst_n2 = 1'b0; salto = 1'b0; dir_salto = '0;
    inst_ready = 1'b0; inst_ready2 = 1'b0; mpc = '0;
    test_reset();
    test_flujo();
    test_contrapresion();
    test_salto();
    test_salto_pop();
    test_wrap();
    test_reset_asincrono();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
